seg_display_arbiter: RTL

//  Owns the 16-bit value shown on the 4-digit seven-segment driver and shares it between two requesters.

---
 rtl/seg_display_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Owns the 16-bit value shown on the 4-digit seven-segment driver and shares
//   it between the CPU (MMIO writes) and a result source. A new owner keeps the
//   display for at least HOLD_CYCLES cycles; the current owner may update its
//   value at any time without extending the hold.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   cpu_req     CPU request (level), cpu_data stable while high
//   cpu_data    CPU digits, [15:12]=digit3 ... [3:0]=digit0
//   cpu_ack     one-cycle pulse, cpu_data latched
//   res_req     result-source request (level)
//   res_data    result digits
//   res_ack     one-cycle pulse, res_data latched
//   clr         synchronous clear, overrides any grant
//   disp_data   value to the scan driver
//   disp_owner  00 none, 01 cpu, 10 res
//   hold_busy   high while the hold counter is non-zero
//   disp_blank  blank request to the driver
//
// Build option
//   SEG_BLINK_EN  when defined, disp_blank toggles every BLINK_HALF cycles while
//                 idle; otherwise disp_blank is tied low and BLINK_HALF unused.

module seg_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned BLINK_HALF  = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_data,
    output logic        cpu_ack,
    input  logic        res_req,
    input  logic [15:0] res_data,
    output logic        res_ack,
    input  logic        clr,
    output logic [15:0] disp_data,
    output logic [1:0]  disp_owner,
    output logic        hold_busy,
    output logic        disp_blank
);

    localparam int unsigned DATA_W = 16;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_RES  = 2'b10;

    // rr_last encoding: 0 = cpu won last, 1 = res won last
    localparam logic RR_CPU = 1'b0;
    localparam logic RR_RES = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FREE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_nxt;
    logic [CNT_W-1:0]    hold_cnt_q;
    logic [CNT_W-1:0]    hold_cnt_nxt;
    logic                rr_last_q;
    logic                rr_last_nxt;

    logic                arb_open;
    logic                cpu_elig;
    logic                res_elig;
    logic                grant_cpu;
    logic                grant_res;
    logic                owner_chg;

    logic [DATA_W-1:0]   disp_data_nxt;
    logic [1:0]          disp_owner_nxt;
    logic                cpu_ack_nxt;
    logic                res_ack_nxt;
    logic                hold_busy_nxt;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rr_last_q  <= RR_CPU;
            disp_data  <= '0;
            disp_owner <= OWN_NONE;
            cpu_ack    <= 1'b0;
            res_ack    <= 1'b0;
            hold_busy  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            hold_cnt_q <= hold_cnt_nxt;
            rr_last_q  <= rr_last_nxt;
            disp_data  <= disp_data_nxt;
            disp_owner <= disp_owner_nxt;
            cpu_ack    <= cpu_ack_nxt;
            res_ack    <= res_ack_nxt;
            hold_busy  <= hold_busy_nxt;
        end
    end

    // Arbitration and next state; a requester whose ack is still high is
    // treated as not yet re-requesting.
    always_comb begin
        state_nxt    = state_q;
        hold_cnt_nxt = (hold_cnt_q != '0) ? hold_cnt_q - CNT_W'(1) : '0;
        grant_cpu    = 1'b0;
        grant_res    = 1'b0;
        owner_chg    = 1'b0;

        arb_open = (state_q == ST_IDLE) || (state_q == ST_FREE);
        cpu_elig = cpu_req && !cpu_ack && (arb_open || (disp_owner == OWN_CPU));
        res_elig = res_req && !res_ack && (arb_open || (disp_owner == OWN_RES));

        if (cpu_elig && res_elig) begin
            grant_res = (rr_last_q == RR_CPU);
            grant_cpu = (rr_last_q == RR_RES);
        end else begin
            grant_cpu = cpu_elig;
            grant_res = res_elig;
        end

        if ((state_q == ST_HOLD) && (hold_cnt_q <= CNT_W'(1))) begin
            state_nxt = ST_FREE;
        end

        owner_chg = (grant_cpu && (disp_owner != OWN_CPU)) ||
                    (grant_res && (disp_owner != OWN_RES));

        // A hold of a single cycle is already over by the next edge
        if (owner_chg) begin
            hold_cnt_nxt = HOLD_RELOAD;
            state_nxt    = (HOLD_CYCLES > 1) ? ST_HOLD : ST_FREE;
        end

        if (clr) begin
            grant_cpu    = 1'b0;
            grant_res    = 1'b0;
            state_nxt    = ST_IDLE;
            hold_cnt_nxt = '0;
        end
    end

    // Output values for the next cycle
    always_comb begin
        disp_data_nxt  = disp_data;
        disp_owner_nxt = disp_owner;
        cpu_ack_nxt    = 1'b0;
        res_ack_nxt    = 1'b0;
        rr_last_nxt    = rr_last_q;

        if (grant_cpu) begin
            disp_data_nxt  = cpu_data;
            disp_owner_nxt = OWN_CPU;
            cpu_ack_nxt    = 1'b1;
            rr_last_nxt    = RR_CPU;
        end else if (grant_res) begin
            disp_data_nxt  = res_data;
            disp_owner_nxt = OWN_RES;
            res_ack_nxt    = 1'b1;
            rr_last_nxt    = RR_RES;
        end

        if (clr) begin
            disp_data_nxt  = '0;
            disp_owner_nxt = OWN_NONE;
        end

        hold_busy_nxt = (hold_cnt_nxt != '0);
    end

`ifdef SEG_BLINK_EN
    logic [CNT_W-1:0] blink_cnt_q;
    logic [CNT_W-1:0] blink_cnt_nxt;
    logic             disp_blank_nxt;

    // Idle blink; restarts whenever the display leaves idle or is cleared
    always_comb begin
        blink_cnt_nxt  = '0;
        disp_blank_nxt = 1'b0;
        if ((state_nxt == ST_IDLE) && !clr) begin
            if (blink_cnt_q == CNT_W'(BLINK_HALF - 1)) begin
                blink_cnt_nxt  = '0;
                disp_blank_nxt = !disp_blank;
            end else begin
                blink_cnt_nxt  = blink_cnt_q + CNT_W'(1);
                disp_blank_nxt = disp_blank;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            disp_blank  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_nxt;
            disp_blank  <= disp_blank_nxt;
        end
    end
`else
    logic blink_unused;
    assign blink_unused = |BLINK_HALF;
    assign disp_blank   = 1'b0;
`endif

endmodule
